// File: rtl/rot_seq_ctrl_if.sv
// DMA read/write handshake bundle between the rotate sequencer (master) and the DMA port (slave).
interface rot_seq_ctrl_if #(
  parameter int PIX_W = 8
);
  logic             O_RD_REQ;
  logic [31:0]      O_RD_ADDR;
  logic             I_RD_GNT;
  logic             I_RD_VALID;
  logic [PIX_W-1:0] I_RD_DATA;
  logic             O_WR_REQ;
  logic [31:0]      O_WR_ADDR;
  logic [PIX_W-1:0] O_WR_DATA;
  logic             I_WR_GNT;

  modport master (
    output O_RD_REQ, O_RD_ADDR, O_WR_REQ, O_WR_ADDR, O_WR_DATA,
    input  I_RD_GNT, I_RD_VALID, I_RD_DATA, I_WR_GNT
  );

  modport slave (
    input  O_RD_REQ, O_RD_ADDR, O_WR_REQ, O_WR_ADDR, O_WR_DATA,
    output I_RD_GNT, I_RD_VALID, I_RD_DATA, I_WR_GNT
  );
endinterface

// File: rtl/rot_seq_ctrl.sv
// Image-rotate sequencer: walks the source row-major, one read + one rotated write per pixel,
// and owns busy/done/interrupt status.
module rot_seq_ctrl #(
  parameter int PIX_W     = 8,
  parameter int PIX_BYTES = 1
) (
  input  logic        I_PCLK,
  input  logic        I_PRESET_N,
  input  logic [31:0] I_DMA_SRC_IMG,
  input  logic [31:0] I_DMA_DST_IMG,
  input  logic [15:0] I_ROT_IMG_H,
  input  logic [15:0] I_ROT_IMG_W,
  input  logic [1:0]  I_ROT_IMG_MODE,
  input  logic        I_ROT_IMG_DIR,
  input  logic        I_CTRL_START,
  input  logic        I_CTRL_RESET,
  input  logic        I_CTRL_INTR_MASK,
  input  logic        I_CTRL_INTR_CLEAR,
  rot_seq_ctrl_if.master dma,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_INTERRUPT
);
  localparam logic [31:0] BYTES32 = 32'(PIX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      row, col;
  logic             start_q;
  logic [PIX_W-1:0] pix;

  logic        start_edge, last_col, last_row, empty_img;
  logic [1:0]  ang;
  logic [31:0] h32, w32, r32, c32, rinv, cinv, src_idx, dst_idx;

  assign start_edge = I_CTRL_START & ~start_q;
  assign last_col   = (col == I_ROT_IMG_W - 16'd1);
  assign last_row   = (row == I_ROT_IMG_H - 16'd1);
  assign empty_img  = (I_ROT_IMG_H == 16'd0) || (I_ROT_IMG_W == 16'd0);

  // Counter-clockwise only mirrors the quarter turns; 0 and 180 are direction-free.
  assign ang = (I_ROT_IMG_DIR && I_ROT_IMG_MODE[0]) ? (I_ROT_IMG_MODE ^ 2'b10) : I_ROT_IMG_MODE;

  assign h32     = {16'd0, I_ROT_IMG_H};
  assign w32     = {16'd0, I_ROT_IMG_W};
  assign r32     = {16'd0, row};
  assign c32     = {16'd0, col};
  assign rinv    = h32 - 32'd1 - r32;
  assign cinv    = w32 - 32'd1 - c32;
  assign src_idx = r32 * w32 + c32;

  always_comb begin
    dst_idx = src_idx;
    case (ang)
      2'd1:    dst_idx = c32 * h32 + rinv;
      2'd2:    dst_idx = rinv * w32 + cinv;
      2'd3:    dst_idx = cinv * h32 + r32;
      default: dst_idx = src_idx;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_edge) state_nxt = empty_img ? S_DONE : S_RD_REQ;
      S_RD_REQ:  if (dma.I_RD_GNT) state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (dma.I_RD_VALID) state_nxt = S_WR_REQ;
      S_WR_REQ:  if (dma.I_WR_GNT) state_nxt = (last_row && last_col) ? S_DONE : S_RD_REQ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (I_CTRL_RESET) state_nxt = S_IDLE;
  end

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      row         <= '0;
      col         <= '0;
      pix         <= '0;
      O_INTERRUPT <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= I_CTRL_START;
      if (I_CTRL_RESET || state == S_IDLE) begin
        row <= '0;
        col <= '0;
      end else if (state == S_WR_REQ && dma.I_WR_GNT) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? 16'd0 : row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
      if (state == S_RD_WAIT && dma.I_RD_VALID) pix <= dma.I_RD_DATA;
      // Set beats clear when both land in the same cycle.
      if (state == S_DONE && !I_CTRL_INTR_MASK) O_INTERRUPT <= 1'b1;
      else if (I_CTRL_INTR_CLEAR)               O_INTERRUPT <= 1'b0;
    end
  end

  assign dma.O_RD_REQ  = (state == S_RD_REQ);
  assign dma.O_WR_REQ  = (state == S_WR_REQ);
  assign dma.O_RD_ADDR = (state == S_RD_REQ) ? I_DMA_SRC_IMG + src_idx * BYTES32 : 32'd0;
  assign dma.O_WR_ADDR = (state == S_WR_REQ) ? I_DMA_DST_IMG + dst_idx * BYTES32 : 32'd0;
  assign dma.O_WR_DATA = (state == S_WR_REQ) ? pix : '0;
  assign O_BUSY        = (state == S_RD_REQ) || (state == S_RD_WAIT) || (state == S_WR_REQ);
  assign O_DONE        = (state == S_DONE);
endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Scoreboard bench for rot_seq_ctrl: stimulus queues expected DMA traffic, a negedge DMA model
// answers requests and checks each granted read/write against the queues.
module tb_rot_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src = 32'h1000;
  logic [31:0] dst = 32'h2000;
  logic [15:0] img_h = 16'd2;
  logic [15:0] img_w = 16'd3;
  logic [1:0]  mode = 2'd0;
  logic        dir = 1'b0, start = 1'b0, creset = 1'b0, mask = 1'b0, iclr = 1'b0;
  logic        busy, done, intr;

  rot_seq_ctrl_if #(.PIX_W(8)) dma();

  rot_seq_ctrl #(.PIX_W(8), .PIX_BYTES(1)) dut (
    .I_PCLK(clk), .I_PRESET_N(rst_n),
    .I_DMA_SRC_IMG(src), .I_DMA_DST_IMG(dst),
    .I_ROT_IMG_H(img_h), .I_ROT_IMG_W(img_w),
    .I_ROT_IMG_MODE(mode), .I_ROT_IMG_DIR(dir),
    .I_CTRL_START(start), .I_CTRL_RESET(creset),
    .I_CTRL_INTR_MASK(mask), .I_CTRL_INTR_CLEAR(iclr),
    .dma(dma),
    .O_BUSY(busy), .O_DONE(done), .O_INTERRUPT(intr)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_rd_q[$];
  logic [39:0] exp_wr_q[$];
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int          mon_chk = 0, mon_pass = 0;
  bit          stall = 1'b0;
  logic [7:0]  salt = 8'h00;
  logic        rd_hs = 1'b0;
  logic [31:0] rd_hs_addr = 32'd0;

  // DMA model + monitor: grant on the negedge a request is seen, return data one cycle later.
  always @(negedge clk) begin
    logic [31:0] e_rd;
    logic [39:0] e_wr;
    if (!rst_n) begin
      dma.I_RD_GNT   = 1'b0;
      dma.I_RD_VALID = 1'b0;
      dma.I_RD_DATA  = 8'h00;
      dma.I_WR_GNT   = 1'b0;
      rd_hs          = 1'b0;
    end else begin
      dma.I_RD_VALID = rd_hs;
      dma.I_RD_DATA  = rd_hs ? (rd_hs_addr[7:0] ^ salt) : 8'h00;
      rd_hs          = dma.O_RD_REQ && (!stall || $urandom_range(0, 1) == 1);
      dma.I_RD_GNT   = rd_hs;
      if (rd_hs) begin
        rd_hs_addr = dma.O_RD_ADDR;
        rd_cnt++;
        mon_chk++;
        if (exp_rd_q.size() == 0)
          $display("FAIL rd_extra: got read %0h, required no read", dma.O_RD_ADDR);
        else begin
          e_rd = exp_rd_q.pop_front();
          if (dma.O_RD_ADDR === e_rd) mon_pass++;
          else $display("FAIL rd_addr: got %0h required %0h", dma.O_RD_ADDR, e_rd);
        end
      end
      dma.I_WR_GNT = dma.O_WR_REQ && (!stall || $urandom_range(0, 1) == 1);
      if (dma.I_WR_GNT) begin
        wr_cnt++;
        mon_chk++;
        if (exp_wr_q.size() == 0)
          $display("FAIL wr_extra: got write %0h/%0h, required no write", dma.O_WR_ADDR, dma.O_WR_DATA);
        else begin
          e_wr = exp_wr_q.pop_front();
          if ({dma.O_WR_ADDR, dma.O_WR_DATA} === e_wr) mon_pass++;
          else $display("FAIL wr_addr_data: got %0h/%0h required %0h/%0h",
                        dma.O_WR_ADDR, dma.O_WR_DATA, e_wr[39:8], e_wr[7:0]);
        end
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ord holds the destination offset of source pixel i in nibble i (first pixel in the top nibble).
  task automatic push_job(input logic [23:0] ord, input int n_rd, input int n_wr);
    logic [31:0] a, wa;
    logic [3:0]  o;
    for (int i = 0; i < n_rd; i++) exp_rd_q.push_back(src + 32'(i));
    for (int i = 0; i < n_wr; i++) begin
      a  = src + 32'(i);
      o  = ord[23-4*i -: 4];
      wa = dst + {28'd0, o};
      exp_wr_q.push_back({wa, a[7:0] ^ salt});
    end
  endtask

  task automatic run_job(input string tag, input logic [1:0] m, input logic d, input logic [23:0] ord,
                         input logic msk, input logic exp_intr, input int exp_busy);
    int rd0, wr0, dn0, bz0;
    iclr = 1'b1;
    tick();
    iclr = 1'b0;
    check({tag, "_intr_clr"}, 64'(intr), 64'd0);
    mode = m; dir = d; mask = msk;
    salt = salt + 8'h3C;
    push_job(ord, 6, 6);
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt; bz0 = busy_cnt;
    start = 1'b1;
    for (int k = 0; k < 300 && done_cnt == dn0; k++) tick();
    tick();
    check({tag, "_done_cnt"}, 64'(done_cnt - dn0), 64'd1);
    check({tag, "_rd_cnt"}, 64'(rd_cnt - rd0), 64'd6);
    check({tag, "_wr_cnt"}, 64'(wr_cnt - wr0), 64'd6);
    check({tag, "_rd_q_empty"}, 64'(exp_rd_q.size()), 64'd0);
    check({tag, "_wr_q_empty"}, 64'(exp_wr_q.size()), 64'd0);
    check({tag, "_intr"}, 64'(intr), 64'(exp_intr));
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, 64'(busy_cnt - bz0), 64'(exp_busy));
    start = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rd0, wr0, dn0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_intr", 64'(intr), 64'd0);
    check("rst_rd_req", 64'(dma.O_RD_REQ), 64'd0);
    check("rst_wr_req", 64'(dma.O_WR_REQ), 64'd0);
    check("rst_rd_addr", 64'(dma.O_RD_ADDR), 64'd0);
    check("rst_wr_addr", 64'(dma.O_WR_ADDR), 64'd0);
    check("rst_wr_data", 64'(dma.O_WR_DATA), 64'd0);
    rst_n = 1'b1;
    tick();

    run_job("m0",     2'd0, 1'b0, 24'h012345, 1'b0, 1'b1, 18);
    run_job("m90",    2'd1, 1'b0, 24'h135024, 1'b0, 1'b1, 18);
    run_job("m180",   2'd2, 1'b0, 24'h543210, 1'b0, 1'b1, 18);
    run_job("m90ccw", 2'd1, 1'b1, 24'h420531, 1'b0, 1'b1, 18);
    stall = 1'b1;
    run_job("m270_stall", 2'd3, 1'b0, 24'h420531, 1'b0, 1'b1, -1);
    stall = 1'b0;
    run_job("m270ccw", 2'd3, 1'b1, 24'h135024, 1'b0, 1'b1, 18);
    run_job("masked",  2'd0, 1'b0, 24'h012345, 1'b1, 1'b0, 18);
    mask = 1'b0;

    // Empty image: straight to DONE, no DMA traffic.
    iclr = 1'b1;
    tick();
    iclr = 1'b0;
    img_h = 16'd0; img_w = 16'd5;
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    start = 1'b1;
    tick();
    check("h0_done_pulse", 64'(done), 64'd1);
    check("h0_busy", 64'(busy), 64'd0);
    tick();
    check("h0_done_end", 64'(done), 64'd0);
    check("h0_intr", 64'(intr), 64'd1);
    tick();
    check("h0_no_rd", 64'(rd_cnt - rd0), 64'd0);
    check("h0_no_wr", 64'(wr_cnt - wr0), 64'd0);
    check("h0_one_done", 64'(done_cnt - dn0), 64'd1);
    start = 1'b0;
    img_h = 16'd2; img_w = 16'd3;
    tick();

    // Soft reset while waiting for the third pixel's read data.
    mode = 2'd0; dir = 1'b0;
    salt = salt + 8'h3C;
    push_job(24'h012345, 3, 2);
    rd0 = rd_cnt; dn0 = done_cnt;
    start = 1'b1;
    for (int k = 0; k < 100 && rd_cnt - rd0 < 3; k++) tick();
    check("srst_pre_busy", 64'(busy), 64'd1);
    creset = 1'b1;
    tick();
    check("srst_busy", 64'(busy), 64'd0);
    check("srst_rd_req", 64'(dma.O_RD_REQ), 64'd0);
    check("srst_wr_req", 64'(dma.O_WR_REQ), 64'd0);
    check("srst_intr_kept", 64'(intr), 64'd1);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    tick();
    check("srst_start_ignored", 64'(busy), 64'd0);
    creset = 1'b0;
    tick();
    tick();
    check("srst_still_idle", 64'(busy), 64'd0);
    check("srst_no_done", 64'(done_cnt - dn0), 64'd0);
    check("srst_rd_cnt", 64'(rd_cnt - rd0), 64'd3);
    check("srst_rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
    check("srst_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    start = 1'b0;
    tick();
    run_job("restart", 2'd0, 1'b0, 24'h012345, 1'b0, 1'b1, 18);

    // Clear held through DONE: set wins for one cycle, then clear takes it down.
    iclr = 1'b1;
    mode = 2'd0;
    salt = salt + 8'h3C;
    push_job(24'h012345, 6, 6);
    start = 1'b1;
    for (int k = 0; k < 300 && done !== 1'b1; k++) tick();
    check("clr_done_seen", 64'(done), 64'd1);
    tick();
    check("clr_intr_set", 64'(intr), 64'd1);
    tick();
    check("clr_intr_cleared", 64'(intr), 64'd0);
    iclr = 1'b0;
    start = 1'b0;
    tick();
    check("clr_rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
    check("clr_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);

    tick();
    n_chk  += mon_chk;
    n_pass += mon_pass;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
